// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_pkg                                                             |
// | Shared types and constants for the multiplexed display scheduler.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package disp_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_ENT  = 2'b01;
  localparam logic [1:0] SRC_RES  = 2'b10;
  localparam logic [1:0] SRC_ERR  = 2'b11;

  localparam logic [3:0] DIG_OFF = 4'b1111;

  // A digit is blanked only while it and every digit to its left are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] hex);
    logic [3:0] m;
    m[3] = (hex[15:12] == 4'h0);
    m[2] = m[3] && (hex[11:8] == 4'h0);
    m[1] = m[2] && (hex[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] dig_enable_n(input logic [1:0] dix);
    logic [3:0] d;
    d = DIG_OFF;
    d[dix] = 1'b0;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | refresh_prescaler                                                    |
// | Free-running divider: one-cycle tick every PRESCALE clock cycles.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module refresh_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == C_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/display_scan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_scan_sched                                                   |
// | Scans a 4-digit multiplexed display and arbitrates three sources,    |
// | switching source only on frame boundaries.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module display_scan_sched
  import disp_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        err_req,
  input  logic [15:0] err_hex,
  input  logic        res_req,
  input  logic [15:0] res_hex,
  input  logic        ent_req,
  input  logic [15:0] ent_hex,
  input  logic        lzs,
  output logic        err_ack,
  output logic        res_ack,
  output logic        ent_ack,
  output logic [3:0]  DIG,
  output logic [3:0]  HEX_OUT,
  output logic [1:0]  src_sel
);

  localparam bit NO_BLANK = (BLANK_CYC <= 0);
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  logic          tick;
  logic          boundary;

  state_e        state_q;
  logic [1:0]    dix_q;
  logic [BW-1:0] blk_q;
  logic [15:0]   shadow_q;
  logic [3:0]    mask_q;
  logic [1:0]    src_q;
  logic [2:0]    ack_q;
  logic [3:0]    dig_q;
  logic [3:0]    hex_q;

  logic          cap_vld_d;
  logic [1:0]    cap_src_d;
  logic [15:0]   cap_hex_d;
  logic [2:0]    cap_ack_d;
  logic [3:0]    cap_mask_d;

  refresh_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && ((state_q == S_OFF) ||
                             ((state_q == S_SHOW) && (dix_q == 2'd0)));

  // Fixed priority: error over result over entry.
  always_comb begin
    cap_vld_d = 1'b1;
    cap_src_d = SRC_NONE;
    cap_hex_d = 16'h0000;
    cap_ack_d = 3'b000;
    if (err_req) begin
      cap_src_d = SRC_ERR;
      cap_hex_d = err_hex;
      cap_ack_d = 3'b100;
    end else if (res_req) begin
      cap_src_d = SRC_RES;
      cap_hex_d = res_hex;
      cap_ack_d = 3'b010;
    end else if (ent_req) begin
      cap_src_d = SRC_ENT;
      cap_hex_d = ent_hex;
      cap_ack_d = 3'b001;
    end else begin
      cap_vld_d = 1'b0;
    end
    cap_mask_d = lzs ? lz_mask(cap_hex_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      dix_q    <= 2'd3;
      blk_q    <= '0;
      shadow_q <= 16'h0000;
      mask_q   <= 4'b0000;
      src_q    <= SRC_NONE;
      ack_q    <= 3'b000;
      dig_q    <= DIG_OFF;
      hex_q    <= 4'h0;
    end else begin
      ack_q <= 3'b000;
      if (boundary && cap_vld_d) begin
        shadow_q <= cap_hex_d;
        mask_q   <= cap_mask_d;
        src_q    <= cap_src_d;
        ack_q    <= cap_ack_d;
      end

      case (state_q)
        S_OFF: begin
          if (tick) begin
            dix_q <= 2'd3;
            blk_q <= '0;
            if (NO_BLANK) state_q <= S_SHOW;
            else          state_q <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (blk_q == BLK_LAST) begin
            state_q <= S_SHOW;
          end else begin
            blk_q <= blk_q + BW'(1);
          end
        end
        S_SHOW: begin
          if (tick) begin
            dix_q <= dix_q - 2'd1;
            blk_q <= '0;
            if (NO_BLANK) state_q <= S_SHOW;
            else          state_q <= S_BLANK;
          end
        end
        default: begin
          state_q <= S_OFF;
        end
      endcase

      // Outputs follow the state one cycle later; blanked digits still drive HEX_OUT.
      if (state_q == S_SHOW) begin
        hex_q <= shadow_q[{dix_q, 2'b00} +: 4];
        dig_q <= mask_q[dix_q] ? DIG_OFF : dig_enable_n(dix_q);
      end else begin
        dig_q <= DIG_OFF;
      end
    end
  end

  assign err_ack = ack_q[2];
  assign res_ack = ack_q[1];
  assign ent_ack = ack_q[0];
  assign DIG     = dig_q;
  assign HEX_OUT = hex_q;
  assign src_sel = src_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_scan_sched                                                |
// | Self-checking bench against a slot/frame arithmetic reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_display_scan_sched;

  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rq  = 3'b000;   // [2]=err [1]=res [0]=ent
  logic [15:0] hx [3];
  logic        lzs = 1'b0;
  logic        err_ack, res_ack, ent_ack;
  logic [3:0]  DIG, HEX_OUT;
  logic [1:0]  src_sel;
  logic [2:0]  ack_o;

  assign ack_o = {err_ack, res_ack, ent_ack};

  always #5 clk = ~clk;

  display_scan_sched #(
    .PRESCALE  (P),
    .BLANK_CYC (B)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .err_req (rq[2]),
    .err_hex (hx[2]),
    .res_req (rq[1]),
    .res_hex (hx[1]),
    .ent_req (rq[0]),
    .ent_hex (hx[0]),
    .lzs     (lzs),
    .err_ack (err_ack),
    .res_ack (res_ack),
    .ent_ack (ent_ack),
    .DIG     (DIG),
    .HEX_OUT (HEX_OUT),
    .src_sel (src_sel)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Reference model: what is on screen, plus a capture waiting to take effect.
  logic [15:0] m_shadow;
  logic [3:0]  m_mask;
  logic [1:0]  m_src;
  logic [2:0]  m_ack;
  bit          cap_v;
  int          cap_which;
  logic [15:0] cap_hex;
  logic [3:0]  cap_mask;
  logic [3:0]  e_dig;
  logic [3:0]  e_hex;
  bit          e_hexv;
  logic [1:0]  src_code [3] = '{2'b01, 2'b10, 2'b11};

  function automatic bit is_boundary(input int c);
    return (c >= P) && (((c - P) % FRAME) == 0);
  endfunction

  function automatic logic [3:0] lz_model(input logic [15:0] h);
    logic [3:0] m = 4'b0000;
    bit lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (h[4*i +: 4] == 4'h0)) m[i] = 1'b1;
      else lead = 1'b0;
    end
    return m;
  endfunction

  task automatic model_init();
    m_shadow = 16'h0000;
    m_mask   = 4'b0000;
    m_src    = 2'b00;
    m_ack    = 3'b000;
    cap_v    = 1'b0;
  endtask

  // Cycle 1 is the cycle right after reset release; ticks land on multiples of P.
  task automatic model_eval();
    int o, k, d;
    e_dig  = 4'hF;
    e_hex  = 4'h0;
    e_hexv = 1'b0;
    if (cyc >= P + 2) begin
      o = (cyc - P - 2) % P;
      k = (cyc - P - 2) / P;
      d = 3 - (k % 4);
      if (o >= B) begin
        e_hexv = 1'b1;
        e_hex  = m_shadow[4*d +: 4];
        if (!m_mask[d]) e_dig = 4'(~(4'b0001 << d));
      end
    end
  endtask

  task automatic model_commit();
    int sel;
    if (cap_v) begin
      m_shadow      = cap_hex;
      m_mask        = cap_mask;
      rq[cap_which] = 1'b0;
      cap_v         = 1'b0;
    end
    m_ack = 3'b000;
    if (is_boundary(cyc)) begin
      sel = -1;
      for (int s = 0; s < 3; s++) if (rq[s]) sel = s;
      if (sel >= 0) begin
        cap_v      = 1'b1;
        cap_which  = sel;
        cap_hex    = hx[sel];
        cap_mask   = lzs ? lz_model(hx[sel]) : 4'b0000;
        m_src      = src_code[sel];
        m_ack[sel] = 1'b1;
      end
    end
  endtask

  task automatic next_cycle();
    model_commit();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 1;
    model_init();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hx[0] = 16'h1234; hx[1] = 16'h5678; hx[2] = 16'h9ABC;
    repeat (2) @(negedge clk);
    n_cmp++; if (DIG !== 4'b1111) begin n_bad++; $display("FAIL reset_dig got %b want 1111", DIG); end
    n_cmp++; if (HEX_OUT !== 4'h0) begin n_bad++; $display("FAIL reset_hex got %h want 0", HEX_OUT); end
    n_cmp++; if (src_sel !== 2'b00) begin n_bad++; $display("FAIL reset_src got %b want 00", src_sel); end
    n_cmp++; if (ack_o !== 3'b000) begin n_bad++; $display("FAIL reset_ack got %b want 000", ack_o); end
  endtask

  task automatic test_idle();
    rq = 3'b000; lzs = 1'b0;
    apply_reset();
    repeat (90) begin
      model_eval();
      n_cmp++; if (DIG !== e_dig) begin n_bad++; $display("FAIL idle_dig cyc=%0d got %b want %b", cyc, DIG, e_dig); end
      n_cmp++; if (HEX_OUT !== 4'h0) begin n_bad++; $display("FAIL idle_hex cyc=%0d got %h want 0", cyc, HEX_OUT); end
      n_cmp++; if (src_sel !== 2'b00) begin n_bad++; $display("FAIL idle_src cyc=%0d got %b want 00", cyc, src_sel); end
      n_cmp++; if (ack_o !== 3'b000) begin n_bad++; $display("FAIL idle_ack cyc=%0d got %b want 000", cyc, ack_o); end
      next_cycle();
    end
  endtask

  task automatic test_capture();
    logic [3:0] shown [4];
    int ack_at = -1;
    int ack_n = 0;
    for (int i = 0; i < 4; i++) shown[i] = 4'hX;
    rq = 3'b010; hx[1] = 16'h12AB; lzs = 1'b0;
    apply_reset();
    repeat (80) begin
      model_eval();
      if (res_ack === 1'b1) begin ack_n++; ack_at = cyc; end
      n_cmp++; if (DIG !== e_dig) begin n_bad++; $display("FAIL cap_dig cyc=%0d got %b want %b", cyc, DIG, e_dig); end
      if (e_hexv) begin
        n_cmp++; if (HEX_OUT !== e_hex) begin n_bad++; $display("FAIL cap_hex cyc=%0d got %h want %h", cyc, HEX_OUT, e_hex); end
      end
      if (cyc >= P + 2 + FRAME && cyc < P + 2 + 2 * FRAME)
        for (int d = 0; d < 4; d++) if (DIG === 4'(~(4'b0001 << d))) shown[d] = HEX_OUT;
      if (cyc == 20) hx[1] = 16'hFFFF;   // mid-frame data change with no new request
      next_cycle();
    end
    n_cmp++; if (ack_at != 9 || ack_n != 1) begin n_bad++; $display("FAIL cap_ack_time got cyc=%0d n=%0d want cyc=9 n=1", ack_at, ack_n); end
    n_cmp++; if (src_sel !== 2'b10) begin n_bad++; $display("FAIL cap_src got %b want 10", src_sel); end
    n_cmp++; if ({shown[3], shown[2], shown[1], shown[0]} !== 16'h12AB) begin
      n_bad++; $display("FAIL cap_frame got %h%h%h%h want 12AB", shown[3], shown[2], shown[1], shown[0]);
    end
  endtask

  task automatic test_priority();
    int at [3];
    for (int s = 0; s < 3; s++) at[s] = -1;
    rq = 3'b111; hx[0] = 16'($urandom); hx[1] = 16'($urandom); hx[2] = 16'($urandom); lzs = 1'b0;
    apply_reset();
    repeat (110) begin
      model_eval();
      for (int s = 0; s < 3; s++) if (ack_o[s] === 1'b1 && at[s] < 0) at[s] = cyc;
      n_cmp++; if (ack_o !== m_ack) begin n_bad++; $display("FAIL prio_ack cyc=%0d got %b want %b", cyc, ack_o, m_ack); end
      n_cmp++; if (src_sel !== m_src) begin n_bad++; $display("FAIL prio_src cyc=%0d got %b want %b", cyc, src_sel, m_src); end
      next_cycle();
    end
    n_cmp++; if (at[2] != 9)  begin n_bad++; $display("FAIL prio_err_at got %0d want 9", at[2]); end
    n_cmp++; if (at[1] != 41) begin n_bad++; $display("FAIL prio_res_at got %0d want 41", at[1]); end
    n_cmp++; if (at[0] != 73) begin n_bad++; $display("FAIL prio_ent_at got %0d want 73", at[0]); end
  endtask

  task automatic test_lzs();
    int shown7 = 0;
    int shown0 = 0;
    int stray = 0;
    rq = 3'b001; hx[0] = 16'h0007; lzs = 1'b1;
    apply_reset();
    repeat (140) begin
      model_eval();
      n_cmp++; if (DIG !== e_dig) begin n_bad++; $display("FAIL lzs_dig cyc=%0d got %b want %b", cyc, DIG, e_dig); end
      if (cyc >= 42 && cyc < 74) begin
        if (DIG === 4'b1110 && HEX_OUT === 4'h7) shown7++;
        else if (DIG !== 4'b1111) stray++;
      end
      if (cyc >= 106 && cyc < 138) begin
        if (DIG === 4'b1110 && HEX_OUT === 4'h0) shown0++;
        else if (DIG !== 4'b1111) stray++;
      end
      if (cyc == 74) begin hx[0] = 16'h0000; rq[0] = 1'b1; end
      next_cycle();
    end
    n_cmp++; if (shown7 != P - B) begin n_bad++; $display("FAIL lzs_0007 got %0d lit cycles want %0d", shown7, P - B); end
    n_cmp++; if (shown0 != P - B) begin n_bad++; $display("FAIL lzs_0000 got %0d lit cycles want %0d", shown0, P - B); end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL lzs_stray got %0d want 0", stray); end
  endtask

  task automatic test_reset_mid();
    int ent_at = -1;
    rq = 3'b010; hx[1] = 16'h5A3C; lzs = 1'b0;
    apply_reset();
    while (cyc < 53) begin
      model_eval();
      next_cycle();
    end
    model_eval();
    n_cmp++; if (DIG !== e_dig || HEX_OUT !== e_hex) begin
      n_bad++; $display("FAIL rmid_pre cyc=%0d got %b/%h want %b/%h", cyc, DIG, HEX_OUT, e_dig, e_hex);
    end
    hx[0] = 16'($urandom); rq[0] = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (DIG !== 4'b1111) begin n_bad++; $display("FAIL rmid_dig got %b want 1111", DIG); end
    n_cmp++; if (HEX_OUT !== 4'h0) begin n_bad++; $display("FAIL rmid_hex got %h want 0", HEX_OUT); end
    n_cmp++; if (src_sel !== 2'b00) begin n_bad++; $display("FAIL rmid_src got %b want 00", src_sel); end
    n_cmp++; if (ack_o !== 3'b000) begin n_bad++; $display("FAIL rmid_ack got %b want 000", ack_o); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
    model_init();
    repeat (60) begin
      model_eval();
      if (ent_ack === 1'b1 && ent_at < 0) ent_at = cyc;
      n_cmp++; if (ack_o !== m_ack) begin n_bad++; $display("FAIL rmid_post_ack cyc=%0d got %b want %b", cyc, ack_o, m_ack); end
      n_cmp++; if (src_sel !== m_src) begin n_bad++; $display("FAIL rmid_post_src cyc=%0d got %b want %b", cyc, src_sel, m_src); end
      next_cycle();
    end
    n_cmp++; if (ent_at != 9) begin n_bad++; $display("FAIL rmid_ent_at got %0d want 9", ent_at); end
  endtask

  function automatic logic [15:0] rand_hex();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(0, 15));
      2:       return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    rq = 3'b000; lzs = 1'b0;
    apply_reset();
    repeat (900) begin
      model_eval();
      n_cmp++; if (DIG !== e_dig) begin n_bad++; $display("FAIL rnd_dig cyc=%0d got %b want %b", cyc, DIG, e_dig); end
      if (e_hexv) begin
        n_cmp++; if (HEX_OUT !== e_hex) begin n_bad++; $display("FAIL rnd_hex cyc=%0d got %h want %h", cyc, HEX_OUT, e_hex); end
      end
      n_cmp++; if (src_sel !== m_src) begin n_bad++; $display("FAIL rnd_src cyc=%0d got %b want %b", cyc, src_sel, m_src); end
      n_cmp++; if (ack_o !== m_ack) begin n_bad++; $display("FAIL rnd_ack cyc=%0d got %b want %b", cyc, ack_o, m_ack); end
      for (int s = 0; s < 3; s++) begin
        if (!rq[s]) begin
          if ($urandom_range(0, 24) == 0) begin rq[s] = 1'b1; hx[s] = rand_hex(); end
          else if ($urandom_range(0, 3) == 0) hx[s] = rand_hex();
        end else if (!(cap_v && cap_which == s) && $urandom_range(0, 79) == 0) begin
          rq[s] = 1'b0;
        end
      end
      lzs = 1'($urandom_range(0, 1));
      next_cycle();
    end
  endtask

  initial begin
    hx[0] = 16'h0000; hx[1] = 16'h0000; hx[2] = 16'h0000;
    test_reset();
    test_idle();
    test_capture();
    test_priority();
    test_lzs();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
